// File: rtl/raw_frame_loader.sv
// Raw Bayer frame loader: raster pixels -> raw memory, then launches demosaic.
// Optional build macro BLACK_LEVEL_EN subtracts a clamped black level from each pixel.
module raw_frame_loader #(
    parameter int ADDR_W = 17,
    parameter int ROW_W  = 11,
    parameter int COL_W  = 11,
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROW_W-1:0]  rowMax,
    input  logic [COL_W-1:0]  colMax,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] black_level,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cfa_start,
    input  logic              cfa_done,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]  rmax_q, rmax_d;
    logic [COL_W-1:0]  cmax_q, cmax_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              done_q;

    logic              beat;
    logic              take;
    logic              in_idle;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  cur_col;
    logic [ADDR_W-1:0] cur_addr;
    logic [ROW_W-1:0]  use_rm;
    logic [COL_W-1:0]  use_cm;
    logic              last_col;
    logic              last_pix;
    logic              done_rise;
    logic [DATA_W-1:0] pix;

`ifdef BLACK_LEVEL_EN
    assign pix = (s_data < black_level) ? '0 : s_data - black_level;
`else
    logic unused_black;
    assign unused_black = ^black_level;
    assign pix = s_data;
`endif

    assign in_idle   = (state_q == S_IDLE);
    assign beat      = s_valid && s_ready;
    assign take      = beat && (s_sof || state_q == S_LOAD);
    assign done_rise = cfa_done && !done_q;

    // An s_sof beat always restarts at pixel (0,0); geometry is live only in IDLE.
    assign cur_row  = s_sof ? '0 : row_q;
    assign cur_col  = s_sof ? '0 : col_q;
    assign cur_addr = s_sof ? '0 : addr_q;
    assign use_rm   = in_idle ? rowMax : rmax_q;
    assign use_cm   = in_idle ? colMax : cmax_q;
    assign last_col = (cur_col == use_cm);
    assign last_pix = last_col && (cur_row == use_rm);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            rmax_q  <= '0;
            cmax_q  <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            rmax_q  <= rmax_d;
            cmax_q  <= cmax_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            done_q  <= cfa_done;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (beat && s_sof) begin
                    state_d = last_pix ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (beat && last_pix) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (done_rise) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        rmax_d  = rmax_q;
        cmax_d  = cmax_q;
        we_d    = 1'b0;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;
        if (take) begin
            we_d    = 1'b1;
            maddr_d = cur_addr;
            wdata_d = pix;
            addr_d  = cur_addr + 1'b1;
            col_d   = last_col ? '0 : cur_col + 1'b1;
            row_d   = last_col ? cur_row + 1'b1 : cur_row;
            err_d   = s_sof && (state_q == S_LOAD);
            if (in_idle) begin
                rmax_d = rowMax;
                cmax_d = colMax;
            end
        end
    end

    always_comb begin
        s_ready   = 1'b0;
        busy      = 1'b1;
        cfa_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
            end
            S_LOAD:  s_ready = 1'b1;
            S_START: cfa_start = 1'b1;
            S_WAIT:  ;
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_raw_frame_loader.sv
// Directed self-checking bench for raw_frame_loader.
// Expected values are hand-computed per vector.
module tb_raw_frame_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] rowMax;
    logic [10:0] colMax;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data;
    logic        s_sof;
    logic [11:0] black_level;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        cfa_start;
    logic        cfa_done;
    logic        busy;
    logic        frame_err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef BLACK_LEVEL_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    raw_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .rowMax     (rowMax),
        .colMax     (colMax),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .black_level(black_level),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cfa_start  (cfa_start),
        .cfa_done   (cfa_done),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        step;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic wr(input string tag, input int a, input int d);
        chk({tag, "_we"}, mem_we, 1);
        chk({tag, "_addr"}, mem_addr, a);
        chk({tag, "_data"}, mem_wdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_sof = 1'b0;
        rowMax = 11'd1;
        colMax = 11'd2;
        cfa_done = 1'b0;
        black_level = 12'd64;
        step;
        step;
        chk("rst_ready", s_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_start", cfa_start, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            push(12'h111 * (i + 1), 1'b0);
            chk("discard_we", mem_we, 0);
            chk("discard_busy", busy, 0);
        end

        cfa_done = 1'b1;
        push(12'hA00, 1'b1);
        wr("f1", 0, 12'hA00);
        chk("f1_start", cfa_start, 0);
        rowMax = 11'd0;
        colMax = 11'd0;
        for (int i = 1; i < 6; i++) begin
            push(12'hA00 + 12'(i), 1'b0);
            wr("f1", i, 12'hA00 + i);
            chk("f1_start", cfa_start, (i == 5));
        end
        chk("f1_ready", s_ready, 0);

        s_valid = 1'b1;
        s_data = 12'hFFF;
        s_sof = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
            chk("hold_we", mem_we, 0);
            chk("hold_busy", busy, 1);
            chk("hold_ready", s_ready, 0);
            chk("hold_start", cfa_start, 0);
        end
        s_valid = 1'b0;
        s_sof = 1'b0;
        cfa_done = 1'b0;
        step;
        chk("low_busy", busy, 1);
        cfa_done = 1'b1;
        step;
        chk("rise_ready", s_ready, 1);
        chk("rise_busy", busy, 0);

        rowMax = 11'd1;
        colMax = 11'd2;
        cfa_done = 1'b0;
        push(12'hB00, 1'b1);
        wr("rs0", 0, 12'hB00);
        push(12'hB01, 1'b0);
        wr("rs1", 1, 12'hB01);
        push(12'hB02, 1'b0);
        wr("rs2", 2, 12'hB02);
        chk("rs_noerr", frame_err, 0);
        push(12'hB03, 1'b1);
        wr("rs_sof", 0, 12'hB03);
        chk("rs_err", frame_err, 1);
        for (int i = 1; i < 6; i++) begin
            push(12'hB03 + 12'(i), 1'b0);
            wr("rs", i, 12'hB03 + i);
            chk("rs_err_clr", frame_err, 0);
            chk("rs_start", cfa_start, (i == 5));
        end
        step;
        chk("rs_wait_start", cfa_start, 0);
        chk("rs_wait_busy", busy, 1);
        cfa_done = 1'b1;
        step;
        chk("rs_idle", s_ready, 1);

        rowMax = 11'd0;
        colMax = 11'd0;
        cfa_done = 1'b0;
        push(12'hC5A, 1'b1);
        wr("one", 0, 12'hC5A);
        chk("one_start", cfa_start, 1);
        step;
        chk("one_start_clr", cfa_start, 0);
        chk("one_ready", s_ready, 0);

        rst = 1'b1;
        step;
        chk("rstw_busy", busy, 0);
        chk("rstw_we", mem_we, 0);
        rst = 1'b0;
        push(12'hD00, 1'b0);
        chk("rstw_discard", mem_we, 0);

        rowMax = 11'd1;
        colMax = 11'd2;
        push(12'hE00, 1'b1);
        wr("rl0", 0, 12'hE00);
        push(12'hE01, 1'b0);
        wr("rl1", 1, 12'hE01);
        rst = 1'b1;
        s_valid = 1'b1;
        s_data = 12'hE02;
        step;
        chk("rstl_we", mem_we, 0);
        chk("rstl_addr", mem_addr, 0);
        chk("rstl_busy", busy, 0);
        chk("rstl_ready", s_ready, 1);
        rst = 1'b0;
        push(12'hE03, 1'b0);
        chk("rstl_discard", mem_we, 0);
        chk("rstl_idle", busy, 0);

        rowMax = 11'd0;
        colMax = 11'd1;
        push(12'd100, 1'b1);
        wr("bl0", 0, BL ? 36 : 100);
        push(12'd30, 1'b0);
        wr("bl1", 1, BL ? 0 : 30);
        chk("bl_start", cfa_start, 1);
        step;
        cfa_done = 1'b1;
        step;
        chk("bl_idle", s_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
